// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the multi-cycle MIPS control unit:
//   - machine-cycle state encoding (visible on count_state)
//   - opcode / funct field constants of the supported instructions
//   - ALU operation codes and ALU B-operand select codes
//   - instruction-class enum latched in DECODE
// Build option: MIPS_CTRL_BRANCH_EN (see mips_main_decoder / mips_multicycle_ctrl).
// -----------------------------------------------------------------------------
package mips_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_WB     = 3'd4,   // write-back, store or load access
        S_DUMMY  = 3'd5    // instruction retire cycle
    } state_e;

    // Opcode field IR[31:26]
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // Funct field IR[5:0] for R-type
    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;

    // ALU operation codes (zero-extended/truncated to ALUOP_WIDTH at the top)
    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_SLL = 4'd4;
    localparam logic [3:0] ALU_LUI = 4'd5;

    // ALU B-operand select
    localparam logic [1:0] SRC_B_RT   = 2'd0;
    localparam logic [1:0] SRC_B_FOUR = 2'd1;
    localparam logic [1:0] SRC_B_SEXT = 2'd2;
    localparam logic [1:0] SRC_B_ZEXT = 2'd3;

    // Illegal instructions decode to CLS_NOP so EXEC/WB raise no strobes.
    typedef enum logic [3:0] {
        CLS_NOP,
        CLS_ADD,
        CLS_AND,
        CLS_OR,
        CLS_SLL,
        CLS_ADDI,
        CLS_ANDI,
        CLS_ORI,
        CLS_LUI,
        CLS_LW,
        CLS_SW,
        CLS_BEQ,
        CLS_BNE
    } instr_class_e;

    function automatic logic is_rtype(input instr_class_e cls);
        return (cls == CLS_ADD) || (cls == CLS_AND) || (cls == CLS_OR) || (cls == CLS_SLL);
    endfunction

    function automatic logic is_itype_alu(input instr_class_e cls);
        return (cls == CLS_ADDI) || (cls == CLS_ANDI) || (cls == CLS_ORI) || (cls == CLS_LUI);
    endfunction

endpackage

// File: rtl/mips_main_decoder.sv
// -----------------------------------------------------------------------------
// mips_main_decoder
// Purely combinational map from opcode/funct to instruction class + illegal flag.
// Ports:
//   opcode_i  [5:0]  IR[31:26]
//   funct_i   [5:0]  IR[5:0]
//   class_o          decoded instruction class (CLS_NOP when illegal)
//   illegal_o        instruction not supported by this controller
// Build option: MIPS_CTRL_BRANCH_EN -- when undefined, beq/bne decode as illegal.
// -----------------------------------------------------------------------------
module mips_main_decoder
    import mips_pkg::*;
(
    input  logic [5:0]   opcode_i,
    input  logic [5:0]   funct_i,
    output instr_class_e class_o,
    output logic         illegal_o
);

    // NOTE: every output gets a default before the case so no path leaves it
    // unassigned -- otherwise synthesis infers a latch.
    always_comb begin
        class_o   = CLS_NOP;
        illegal_o = 1'b0;
        case (opcode_i)
            OP_RTYPE: begin
                case (funct_i)
                    FN_ADD:  class_o = CLS_ADD;
                    FN_AND:  class_o = CLS_AND;
                    FN_OR:   class_o = CLS_OR;
                    FN_SLL:  class_o = CLS_SLL;
                    default: illegal_o = 1'b1;
                endcase
            end
            OP_ADDI: class_o = CLS_ADDI;
            OP_ANDI: class_o = CLS_ANDI;
            OP_ORI:  class_o = CLS_ORI;
            OP_LUI:  class_o = CLS_LUI;
            OP_LW:   class_o = CLS_LW;
            OP_SW:   class_o = CLS_SW;
`ifdef MIPS_CTRL_BRANCH_EN
            OP_BEQ:  class_o = CLS_BEQ;
            OP_BNE:  class_o = CLS_BNE;
`endif
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// mips_multicycle_ctrl
// Multi-cycle MIPS control FSM: IDLE -> FETCH -> DECODE -> EXEC -> WB -> DUMMY.
// Each instruction takes exactly five cycles; DUMMY loops straight to FETCH
// while enable is high, so back-to-back instructions have no IDLE gap.
// Ports:
//   clk, reset (async, active-low), enable
//   opcode[5:0], funct[5:0]  instruction fields, valid from DECODE onward
//   zero                     ALU zero flag, captured at the end of EXEC
//   count_state[2:0]         current state encoding
//   pc_en, ir_write, reg_write, mem_write, iord, mem_to_reg, reg_dst,
//   alu_src_a, pc_src        datapath strobes/selects
//   alu_src_b[1:0]           0=rt, 1=const 4, 2=sign-ext imm, 3=zero-ext/lui imm
//   alu_op[ALUOP_WIDTH-1:0]  ALU operation
//   illegal                  pulse in DECODE for an undecodable instruction
//   instr_done               pulse in DUMMY
// Build option: MIPS_CTRL_BRANCH_EN -- enables beq/bne; otherwise they are
// illegal and pc_src is tied 0.
// -----------------------------------------------------------------------------
module mips_multicycle_ctrl
    import mips_pkg::*;
#(
    parameter int ALUOP_WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [5:0]             opcode,
    input  logic [5:0]             funct,
    input  logic                   zero,
    output logic [2:0]             count_state,
    output logic                   pc_en,
    output logic                   ir_write,
    output logic                   reg_write,
    output logic                   mem_write,
    output logic                   iord,
    output logic                   mem_to_reg,
    output logic                   reg_dst,
    output logic                   alu_src_a,
    output logic                   pc_src,
    output logic [1:0]             alu_src_b,
    output logic [ALUOP_WIDTH-1:0] alu_op,
    output logic                   illegal,
    output logic                   instr_done
);

    state_e       state_q, state_d;
    instr_class_e class_q;
    instr_class_e dec_class;
    logic         dec_illegal;
    logic         zero_q;
    logic         branch_taken;
    logic [3:0]   alu_op_w;

    mips_main_decoder u_decoder (
        .opcode_i  (opcode),
        .funct_i   (funct),
        .class_o   (dec_class),
        .illegal_o (dec_illegal)
    );

    // Next-state: only IDLE and DUMMY look at enable, so dropping enable
    // mid-instruction never aborts it. Unused codes 6/7 recover to IDLE.
    always_comb begin
        state_d = S_IDLE;
        case (state_q)
            S_IDLE:   state_d = enable ? S_FETCH : S_IDLE;
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: state_d = S_EXEC;
            S_EXEC:   state_d = S_WB;
            S_WB:     state_d = S_DUMMY;
            S_DUMMY:  state_d = enable ? S_FETCH : S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            class_q <= CLS_NOP;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) class_q <= dec_class;
            if (state_q == S_EXEC)   zero_q  <= zero;
        end
    end

`ifdef MIPS_CTRL_BRANCH_EN
    assign branch_taken = ((class_q == CLS_BEQ) &&  zero_q) ||
                          ((class_q == CLS_BNE) && !zero_q);
`else
    logic unused_zero_q;
    assign unused_zero_q = zero_q;
    assign branch_taken  = 1'b0;
`endif

    // Outputs are a pure decode of the registered state and class, so IDLE
    // (including while reset is held) drives every strobe low. illegal is the
    // one exception: it reflects the live opcode/funct during DECODE.
    always_comb begin
        pc_en      = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        mem_write  = 1'b0;
        iord       = 1'b0;
        mem_to_reg = 1'b0;
        reg_dst    = 1'b0;
        alu_src_a  = 1'b0;
        pc_src     = 1'b0;
        alu_src_b  = SRC_B_RT;
        alu_op_w   = ALU_ADD;
        illegal    = 1'b0;
        instr_done = 1'b0;
        case (state_q)
            S_FETCH: begin
                // IR <- mem[PC], PC <- PC + 4
                ir_write  = 1'b1;
                pc_en     = 1'b1;
                alu_src_b = SRC_B_FOUR;
                alu_op_w  = ALU_ADD;
            end
            S_DECODE: illegal = dec_illegal;
            S_EXEC: begin
                alu_src_a = (class_q != CLS_NOP);
                case (class_q)
                    CLS_ADD:  alu_op_w = ALU_ADD;
                    CLS_AND:  alu_op_w = ALU_AND;
                    CLS_OR:   alu_op_w = ALU_OR;
                    CLS_SLL:  alu_op_w = ALU_SLL;
                    CLS_ADDI, CLS_LW, CLS_SW: begin
                        alu_src_b = SRC_B_SEXT;
                        alu_op_w  = ALU_ADD;
                    end
                    CLS_ANDI: begin
                        alu_src_b = SRC_B_ZEXT;
                        alu_op_w  = ALU_AND;
                    end
                    CLS_ORI: begin
                        alu_src_b = SRC_B_ZEXT;
                        alu_op_w  = ALU_OR;
                    end
                    CLS_LUI: begin
                        alu_src_b = SRC_B_ZEXT;
                        alu_op_w  = ALU_LUI;
                    end
                    CLS_BEQ, CLS_BNE: alu_op_w = ALU_SUB;
                    default: ;
                endcase
            end
            S_WB: begin
                if (is_rtype(class_q)) begin
                    reg_write = 1'b1;
                    reg_dst   = 1'b1;
                end else if (is_itype_alu(class_q)) begin
                    reg_write = 1'b1;
                end else if (class_q == CLS_LW) begin
                    iord       = 1'b1;
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                end else if (class_q == CLS_SW) begin
                    iord      = 1'b1;
                    mem_write = 1'b1;
                end else begin
                    pc_en  = branch_taken;
                    pc_src = branch_taken;
                end
            end
            S_DUMMY: instr_done = 1'b1;
            default: ;
        endcase
    end

    assign alu_op      = ALUOP_WIDTH'(alu_op_w);
    assign count_state = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mips_multicycle_ctrl
// Directed self-checking bench for mips_multicycle_ctrl. Strobes are packed
// into one 13-bit vector:
//   {pc_en, ir_write, reg_write, mem_write, iord, mem_to_reg, reg_dst,
//    alu_src_a, pc_src, alu_src_b[1:0], illegal, instr_done}
// Branch expectations follow MIPS_CTRL_BRANCH_EN.
// -----------------------------------------------------------------------------
module tb_mips_multicycle_ctrl;

    localparam logic [12:0] B_PE  = 13'd4096;
    localparam logic [12:0] B_IRW = 13'd2048;
    localparam logic [12:0] B_RW  = 13'd1024;
    localparam logic [12:0] B_MW  = 13'd512;
    localparam logic [12:0] B_IO  = 13'd256;
    localparam logic [12:0] B_M2R = 13'd128;
    localparam logic [12:0] B_RD  = 13'd64;
    localparam logic [12:0] B_ASA = 13'd32;
    localparam logic [12:0] B_PS  = 13'd16;
    localparam logic [12:0] B_SB1 = 13'd4;
    localparam logic [12:0] B_SB2 = 13'd8;
    localparam logic [12:0] B_SB3 = 13'd12;
    localparam logic [12:0] B_ILL = 13'd2;
    localparam logic [12:0] B_DN  = 13'd1;
    localparam logic [12:0] NONE  = 13'd0;

    localparam logic [3:0] A_ADD = 4'd0;
    localparam logic [3:0] A_SUB = 4'd1;
    localparam logic [3:0] A_AND = 4'd2;
    localparam logic [3:0] A_OR  = 4'd3;
    localparam logic [3:0] A_SLL = 4'd4;
    localparam logic [3:0] A_LUI = 4'd5;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic [2:0] count_state;
    logic       pc_en, ir_write, reg_write, mem_write, iord, mem_to_reg;
    logic       reg_dst, alu_src_a, pc_src, illegal, instr_done;
    logic [1:0] alu_src_b;
    logic [3:0] alu_op;

    int checks   = 0;
    int failures = 0;

    mips_multicycle_ctrl #(.ALUOP_WIDTH(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .opcode      (opcode),
        .funct       (funct),
        .zero        (zero),
        .count_state (count_state),
        .pc_en       (pc_en),
        .ir_write    (ir_write),
        .reg_write   (reg_write),
        .mem_write   (mem_write),
        .iord        (iord),
        .mem_to_reg  (mem_to_reg),
        .reg_dst     (reg_dst),
        .alu_src_a   (alu_src_a),
        .pc_src      (pc_src),
        .alu_src_b   (alu_src_b),
        .alu_op      (alu_op),
        .illegal     (illegal),
        .instr_done  (instr_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [12:0] strobes();
        return {pc_en, ir_write, reg_write, mem_write, iord, mem_to_reg, reg_dst,
                alu_src_a, pc_src, alu_src_b, illegal, instr_done};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_cycle(input string tag, input logic [2:0] st,
                               input logic [12:0] sb, input logic [3:0] op);
        check({tag, "_state"},   32'(count_state), 32'(st));
        check({tag, "_strobes"}, 32'(strobes()),   32'(sb));
        check({tag, "_aluop"},   32'(alu_op),      32'(op));
    endtask

    // Runs one instruction from the edge that enters FETCH through DUMMY.
    // zero is held at the opposite value outside EXEC so only the EXEC sample
    // can drive the branch decision.
    task automatic run_instr(input string nm, input logic [31:0] ir, input logic z,
                             input logic ill, input logic [12:0] ex, input logic [3:0] ex_op,
                             input logic [12:0] wb, input logic drop_en);
        opcode = ir[31:26];
        funct  = ir[5:0];
        zero   = ~z;
        step(); check_cycle({nm, "_fetch"},  3'd1, B_PE | B_IRW | B_SB1, A_ADD);
        step(); check_cycle({nm, "_decode"}, 3'd2, ill ? B_ILL : NONE, A_ADD);
        step(); check_cycle({nm, "_exec"},   3'd3, ex, ex_op);
        zero = z;
        if (drop_en) enable = 1'b0;
        step(); check_cycle({nm, "_wb"},     3'd4, wb, A_ADD);
        zero = ~z;
        step(); check_cycle({nm, "_dummy"},  3'd5, B_DN, A_ADD);
    endtask

    initial begin
        reset  = 1'b0;
        enable = 1'b1;
        opcode = 6'h00;
        funct  = 6'h00;
        zero   = 1'b0;

        // Reset held with enable high: must stay in IDLE, outputs quiet.
        step(); step();
        check_cycle("rst_hold", 3'd0, NONE, A_ADD);
        reset  = 1'b1;
        enable = 1'b0;
        step(); check_cycle("idle_en0_a", 3'd0, NONE, A_ADD);
        step(); check_cycle("idle_en0_b", 3'd0, NONE, A_ADD);

        enable = 1'b1;
        run_instr("addi",  32'h21080003, 1'b0, 1'b0, B_ASA | B_SB2, A_ADD, B_RW, 1'b0);
        run_instr("sw",    32'hAD910000, 1'b0, 1'b0, B_ASA | B_SB2, A_ADD, B_MW | B_IO, 1'b0);
        run_instr("lw",    32'h8D940000, 1'b0, 1'b0, B_ASA | B_SB2, A_ADD, B_IO | B_RW | B_M2R, 1'b0);
        run_instr("add",   32'h01095020, 1'b0, 1'b0, B_ASA, A_ADD, B_RW | B_RD, 1'b0);
        run_instr("and",   32'h01095024, 1'b0, 1'b0, B_ASA, A_AND, B_RW | B_RD, 1'b0);
        run_instr("or",    32'h01095025, 1'b0, 1'b0, B_ASA, A_OR,  B_RW | B_RD, 1'b0);
        run_instr("sll",   32'h00084080, 1'b0, 1'b0, B_ASA, A_SLL, B_RW | B_RD, 1'b0);
        run_instr("andi",  32'h3108000F, 1'b0, 1'b0, B_ASA | B_SB3, A_AND, B_RW, 1'b0);
        run_instr("ori",   32'h350800FF, 1'b0, 1'b0, B_ASA | B_SB3, A_OR,  B_RW, 1'b0);
        run_instr("lui",   32'h3C081234, 1'b0, 1'b0, B_ASA | B_SB3, A_LUI, B_RW, 1'b0);
`ifdef MIPS_CTRL_BRANCH_EN
        run_instr("beq_z1", 32'h11090002, 1'b1, 1'b0, B_ASA, A_SUB, B_PE | B_PS, 1'b0);
        run_instr("beq_z0", 32'h11090002, 1'b0, 1'b0, B_ASA, A_SUB, NONE,        1'b0);
        run_instr("bne_z1", 32'h15090002, 1'b1, 1'b0, B_ASA, A_SUB, NONE,        1'b0);
        run_instr("bne_z0", 32'h15090002, 1'b0, 1'b0, B_ASA, A_SUB, B_PE | B_PS, 1'b0);
`else
        run_instr("beq_z1", 32'h11090002, 1'b1, 1'b1, NONE, A_ADD, NONE, 1'b0);
        run_instr("beq_z0", 32'h11090002, 1'b0, 1'b1, NONE, A_ADD, NONE, 1'b0);
        run_instr("bne_z1", 32'h15090002, 1'b1, 1'b1, NONE, A_ADD, NONE, 1'b0);
        run_instr("bne_z0", 32'h15090002, 1'b0, 1'b1, NONE, A_ADD, NONE, 1'b0);
`endif
        run_instr("bad_funct", 32'h01095022, 1'b0, 1'b1, NONE, A_ADD, NONE, 1'b0);
        // Illegal opcode with enable dropped in EXEC: completes, then IDLE.
        run_instr("op3f",  32'hFC000000, 1'b0, 1'b1, NONE, A_ADD, NONE, 1'b1);
        step(); check_cycle("after_drop_a", 3'd0, NONE, A_ADD);
        step(); check_cycle("after_drop_b", 3'd0, NONE, A_ADD);

        // Reset mid-instruction aborts asynchronously.
        enable = 1'b1;
        opcode = 6'h08;
        funct  = 6'h03;
        step(); check("mid_fetch_state", 32'(count_state), 32'd1);
        step(); check("mid_decode_state", 32'(count_state), 32'd2);
        #2 reset = 1'b0;
        #1 check_cycle("mid_rst_async", 3'd0, NONE, A_ADD);
        step(); check_cycle("mid_rst_held", 3'd0, NONE, A_ADD);
        reset  = 1'b1;
        enable = 1'b0;
        step(); check_cycle("mid_rst_idle", 3'd0, NONE, A_ADD);
        enable = 1'b1;
        step(); check_cycle("mid_rst_refetch", 3'd1, B_PE | B_IRW | B_SB1, A_ADD);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_ctrl.md
MIPS_MULTICYCLE_CTRL -- requirements
Module: mips_multicycle_ctrl

Interface
REQ-001 Parameter ALUOP_WIDTH, default 4, width of the ALU operation code.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 enable  input  1  start/continue instruction processing.
REQ-005 opcode  input  6  IR[31:26]; valid from DECODE onward.
REQ-006 funct  input  6  IR[5:0]; valid from DECODE onward.
REQ-007 zero  input  1  ALU zero flag, sampled in EXEC.
REQ-008 count_state  output  3  current machine-cycle state encoding.
REQ-009 pc_en, ir_write, reg_write, mem_write, iord, mem_to_reg, reg_dst, alu_src_a, pc_src  output  1 each  datapath strobes/selects.
REQ-010 alu_src_b  output  2  0=rt, 1=const 4, 2=sign-ext imm, 3=zero-ext/lui imm.
REQ-011 alu_op  output  ALUOP_WIDTH  ALU operation code.
REQ-012 illegal  output  1  one-cycle pulse on undecodable instruction.
REQ-013 instr_done  output  1  one-cycle pulse in DUMMY.

Function
REQ-014 States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, WB=4 (WB/STORE/LOAD), DUMMY=5; codes 6,7 return to IDLE next cycle.
REQ-015 IDLE->FETCH when enable=1; FETCH->DECODE->EXEC->WB->DUMMY unconditionally; DUMMY->FETCH if enable=1, else IDLE.
REQ-016 enable dropping mid-instruction does not abort; current instruction completes through DUMMY.
REQ-017 Each instruction takes exactly 5 cycles (FETCH..DUMMY); back-to-back instructions have no IDLE gap.
REQ-018 FETCH: iord=0, ir_write=1, pc_en=1, pc_src=0, alu_src_a=0, alu_src_b=1, alu_op=ADD (PC+4).
REQ-019 DECODE: opcode/funct decoded and the instruction class registered; class held until next DECODE.
REQ-020 Supported: R-type (opcode 0x00) funct add 0x20, and 0x24, or 0x25, sll 0x00; addi 0x08, andi 0x0C, ori 0x0D, lui 0x0F, lw 0x23, sw 0x2B, beq 0x04, bne 0x05.
REQ-021 EXEC: alu_src_a=1 (sll: shamt path), alu_src_b=0 for R-type/branch, 2 for addi/lw/sw, 3 for andi/ori/lui; alu_op per instruction (branch: SUB).
REQ-022 WB: R-type reg_write=1, reg_dst=1; I-type ALU reg_write=1, reg_dst=0; sw mem_write=1, iord=1; lw iord=1, reg_write=1, mem_to_reg=1.
REQ-023 Branch: zero registered at end of EXEC; in WB pc_en=pc_src=1 iff (beq & zero) | (bne & !zero).
REQ-024 Illegal opcode/funct: illegal=1 in DECODE for one cycle; no reg_write/mem_write/pc_en in EXEC or WB; sequence proceeds to DUMMY.
REQ-025 All strobes 0 in IDLE and DUMMY; strobes asserted only in the states listed above.

Reset
REQ-026 reset=0 forces state IDLE and class register to NOP asynchronously; all outputs 0, count_state=0.
REQ-027 reset asserted mid-instruction aborts immediately; no strobe asserts until reset=1 and enable=1 yield FETCH.

Configuration
REQ-028 MIPS_CTRL_BRANCH_EN defined: beq/bne decoded per REQ-023.
REQ-029 MIPS_CTRL_BRANCH_EN undefined: opcodes 0x04/0x05 treated as illegal (REQ-024); pc_src tied 0.

Structure
REQ-030 Package mips_pkg holds state encoding, opcode/funct constants, ALU op codes, instruction-class enum.
REQ-031 Combinational sub-module mips_main_decoder maps opcode/funct to instruction class and illegal flag.

Verification
REQ-032 reset=0 then 1 with enable=0 -> count_state=0, all outputs 0; enable=1 -> count_state 1,2,3,4,5,1 on consecutive edges.
REQ-033 IR 0x21080003 (addi $t0,$t0,3) -> EXEC alu_src_b=2, alu_op=ADD; WB reg_write=1, reg_dst=0; instr_done in cycle 5.
REQ-034 IR 0xad910000 (sw) then 0x8d940000 (lw) -> WB mem_write=1,iord=1 for sw; reg_write=1,mem_to_reg=1,iord=1 for lw.
REQ-035 IR 0x11090002 (beq) with zero=1 -> WB pc_en=1, pc_src=1; with zero=0 -> pc_en=0; 0x15090002 (bne) inverse.
REQ-036 opcode 0x3F -> illegal pulse in DECODE, no write strobes, next FETCH after DUMMY; enable=0 during EXEC -> completes to DUMMY then IDLE.
